rf_op_sequencer: RTL and testbench

//   Command-driven initiator for the 16x16 register file's port set (Ra/Rb/Rw/WrEn/Wdat
//   in, Adat/Bdat out). Accepts one register-to-register command per handshake, reads

---
 rtl/rf_op_sequencer.sv | 176 +++++++++++++++++
 tb/tb_rf_op_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rf_op_sequencer.sv
// Command-driven register-file initiator: accepts one register-to-register command,
// reads both sources, computes the result and writes it back.
module rf_op_sequencer #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_srca,
  input  logic [AW-1:0] cmd_srcb,
  input  logic [DW-1:0] cmd_imm,
  output logic [AW-1:0] rf_ra,
  output logic [AW-1:0] rf_rb,
  output logic [AW-1:0] rf_rw,
  output logic          rf_wren,
  output logic [DW-1:0] rf_wdat,
  input  logic [DW-1:0] rf_adat,
  input  logic [DW-1:0] rf_bdat,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic          res_zero,
  output logic          res_carry,
  output logic          busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

  state_t        state_q, state_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [AW-1:0] rf_ra_q, rf_ra_d;
  logic [AW-1:0] rf_rb_q, rf_rb_d;
  logic [AW-1:0] rf_rw_q, rf_rw_d;
  logic          rf_wren_q, rf_wren_d;
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] result_q, result_d;
  logic          zero_q, zero_d;
  logic          carry_q, carry_d;

  logic [DW:0]   sum;
  logic [DW:0]   diff;
  logic [DW-1:0] alu_res;
  logic          alu_carry;

  // Bit DW of the extended difference is the unsigned borrow (a < b).
  always_comb begin
    sum       = {1'b0, a_q} + {1'b0, b_q};
    diff      = {1'b0, a_q} - {1'b0, b_q};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin alu_res = sum[DW-1:0];  alu_carry = sum[DW];  end
      OP_SUB: begin alu_res = diff[DW-1:0]; alu_carry = diff[DW]; end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_LDI: alu_res = imm_q;
      OP_SHL: begin alu_res = {a_q[DW-2:0], 1'b0}; alu_carry = a_q[DW-1]; end
      OP_CMP: begin alu_res = diff[DW-1:0]; alu_carry = diff[DW]; end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dst_d       = dst_q;
    imm_d       = imm_q;
    a_d         = a_q;
    b_d         = b_q;
    rf_ra_d     = rf_ra_q;
    rf_rb_d     = rf_rb_q;
    rf_rw_d     = rf_rw_q;
    rf_wren_d   = 1'b0;
    res_valid_d = 1'b0;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d = S_READ;
          op_d    = cmd_op;
          dst_d   = cmd_dst;
          imm_d   = cmd_imm;
          rf_ra_d = cmd_srca;
          rf_rb_d = cmd_srcb;
        end
      end
      S_READ: begin
        a_d     = rf_adat;
        b_d     = rf_bdat;
        state_d = S_EXEC;
      end
      // Write-stage outputs are loaded here so they are valid for the whole WRITE cycle.
      S_EXEC: begin
        state_d     = S_WRITE;
        result_d    = alu_res;
        zero_d      = (alu_res == '0);
        carry_d     = alu_carry;
        rf_rw_d     = dst_q;
        rf_wren_d   = (op_q != OP_CMP);
        res_valid_d = 1'b1;
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      op_q        <= '0;
      dst_q       <= '0;
      imm_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rf_ra_q     <= '0;
      rf_rb_q     <= '0;
      rf_rw_q     <= '0;
      rf_wren_q   <= 1'b0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      op_q        <= op_d;
      dst_q       <= dst_d;
      imm_q       <= imm_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rf_ra_q     <= rf_ra_d;
      rf_rb_q     <= rf_rb_d;
      rf_rw_q     <= rf_rw_d;
      rf_wren_q   <= rf_wren_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = ~cmd_ready_q;
  assign rf_ra     = rf_ra_q;
  assign rf_rb     = rf_rb_q;
  assign rf_rw     = rf_rw_q;
  assign rf_wren   = rf_wren_q;
  assign rf_wdat   = result_q;
  assign res_valid = res_valid_q;
  assign res_data  = result_q;
  assign res_zero  = zero_q;
  assign res_carry = carry_q;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Directed bench for rf_op_sequencer driving a behavioural 16x16 register file.
module tb_rf_op_sequencer;
  localparam int DW = 16;
  localparam int AW = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [AW-1:0] cmd_dst = '0;
  logic [AW-1:0] cmd_srca = '0;
  logic [AW-1:0] cmd_srcb = '0;
  logic [DW-1:0] cmd_imm = '0;
  logic [AW-1:0] rf_ra, rf_rb, rf_rw;
  logic          rf_wren;
  logic [DW-1:0] rf_wdat, rf_adat, rf_bdat;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          res_zero, res_carry, busy;

  logic [DW-1:0] rf [16];
  int            cyc = 0;
  int            last_acc = 0;
  int            n_chk = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rf_wren) rf[rf_rw] <= rf_wdat;
  assign rf_adat = rf[rf_ra];
  assign rf_bdat = rf[rf_rb];

  rf_op_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb), .cmd_imm(cmd_imm),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_rw(rf_rw), .rf_wren(rf_wren), .rf_wdat(rf_wdat),
    .rf_adat(rf_adat), .rf_bdat(rf_bdat),
    .res_valid(res_valid), .res_data(res_data), .res_zero(res_zero),
    .res_carry(res_carry), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one command and follows it through READ/EXEC/WRITE and back to IDLE.
  // hold keeps cmd_valid high afterwards; scramble also changes the fields while busy.
  task automatic do_cmd(input string name, input logic [2:0] op, input logic [3:0] dst,
                        input logic [3:0] sa, input logic [3:0] sb, input logic [15:0] imm,
                        input bit hold, input bit scramble, input bit exp_wren,
                        input logic [15:0] exp_res, input bit exp_zero, input bit exp_carry,
                        input int exp_gap);
    int n;
    cmd_op = op; cmd_dst = dst; cmd_srca = sa; cmd_srcb = sb; cmd_imm = imm;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_accept_wait"}, 32'(n < 20), 1);
    @(posedge clk); #1;
    if (exp_gap != 0) chk({name, "_accept_gap"}, cyc - last_acc, exp_gap);
    last_acc = cyc;
    if (!hold && !scramble) cmd_valid = 1'b0;
    if (scramble) begin
      cmd_op = OP_LDI; cmd_dst = 4'd5; cmd_imm = 16'h0000;
    end
    chk({name, "_read_ready"}, cmd_ready, 0);
    chk({name, "_read_busy"}, busy, 1);
    chk({name, "_rf_ra"}, rf_ra, sa);
    chk({name, "_rf_rb"}, rf_rb, sb);
    chk({name, "_read_wren"}, rf_wren, 0);
    @(posedge clk); #1;
    if (scramble) begin
      cmd_op = OP_SHL; cmd_dst = 4'd12; cmd_srca = 4'd9;
    end
    chk({name, "_exec_ready"}, cmd_ready, 0);
    chk({name, "_exec_wren"}, rf_wren, 0);
    chk({name, "_exec_resv"}, res_valid, 0);
    @(posedge clk); #1;
    chk({name, "_write_ready"}, cmd_ready, 0);
    chk({name, "_write_wren"}, rf_wren, exp_wren);
    chk({name, "_write_resv"}, res_valid, 1);
    if (exp_wren) begin
      chk({name, "_rf_rw"}, rf_rw, dst);
      chk({name, "_rf_wdat"}, rf_wdat, exp_res);
      chk({name, "_res_data"}, res_data, exp_res);
    end
    chk({name, "_zero"}, res_zero, exp_zero);
    chk({name, "_carry"}, res_carry, exp_carry);
    $display("cmd %-6s op=%0d dst=%0d a=%0d b=%0d acc@%0d wren=%0b wdat=%h z=%0b c=%0b",
             name, op, dst, sa, sb, last_acc, rf_wren, rf_wdat, res_zero, res_carry);
    @(posedge clk); #1;
    chk({name, "_idle_ready"}, cmd_ready, 1);
    chk({name, "_idle_wren"}, rf_wren, 0);
    chk({name, "_idle_resv"}, res_valid, 0);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_wren", rf_wren, 0);
    chk("rst_resv", res_valid, 0);
    chk("rst_wdat", rf_wdat, 0);
    chk("rst_ra", rf_ra, 0);
    chk("rst_rw", rf_rw, 0);
    chk("rst_carry", res_carry, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready_before_edge", cmd_ready, 0);
    @(posedge clk); #1;
    chk("rel_ready_after_edge", cmd_ready, 1);

    // Preload sources, then the main operations
    do_cmd("ldi5",  OP_LDI, 4'd5,  4'd0,  4'd0,  16'hABCD, 0, 0, 1, 16'hABCD, 0, 0, 0);
    do_cmd("ldi12", OP_LDI, 4'd12, 4'd0,  4'd0,  16'hE050, 0, 0, 1, 16'hE050, 0, 0, 4);
    do_cmd("add9",  OP_ADD, 4'd9,  4'd5,  4'd12, 16'h0000, 0, 0, 1, 16'h8C1D, 0, 1, 4);
    do_cmd("sub3",  OP_SUB, 4'd3,  4'd12, 4'd12, 16'h0000, 0, 0, 1, 16'h0000, 1, 0, 4);
    do_cmd("cmp",   OP_CMP, 4'd4,  4'd5,  4'd12, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 4);
    chk("cmp_r5_kept", rf[5], 16'hABCD);
    chk("cmp_r12_kept", rf[12], 16'hE050);
    do_cmd("shl1",  OP_SHL, 4'd1,  4'd5,  4'd0,  16'h0000, 0, 0, 1, 16'h579A, 0, 1, 4);
    do_cmd("xor2",  OP_XOR, 4'd2,  4'd5,  4'd5,  16'h0000, 0, 0, 1, 16'h0000, 1, 0, 4);
    do_cmd("and6",  OP_AND, 4'd6,  4'd5,  4'd12, 16'h0000, 0, 0, 1, 16'hA040, 0, 0, 4);

    // Fields change while busy; only the command present in IDLE may execute
    do_cmd("or10",  OP_OR,  4'd10, 4'd5,  4'd12, 16'h0000, 1, 1, 1, 16'hEBDD, 0, 0, 4);
    do_cmd("xor13", OP_XOR, 4'd13, 4'd5,  4'd12, 16'h0000, 0, 0, 1, 16'h4B9D, 0, 0, 4);
    chk("busy_r5_kept", rf[5], 16'hABCD);
    chk("busy_r12_kept", rf[12], 16'hE050);
    chk("r9_written", rf[9], 16'h8C1D);
    chk("r10_written", rf[10], 16'hEBDD);

    // Back-to-back with cmd_valid held; ADD sees the LDI result
    do_cmd("ldi12b", OP_LDI, 4'd12, 4'd0,  4'd0,  16'h529E, 1, 0, 1, 16'h529E, 0, 0, 0);
    do_cmd("add12",  OP_ADD, 4'd12, 4'd12, 4'd12, 16'h0000, 0, 0, 1, 16'hA53C, 0, 0, 4);
    chk("r12_final", rf[12], 16'hA53C);

    // Abort in the middle of WRITE
    do_cmd("ldi7", OP_LDI, 4'd7, 4'd0, 4'd0, 16'h0000, 0, 0, 1, 16'h0000, 1, 0, 0);
    cmd_op = OP_LDI; cmd_dst = 4'd7; cmd_imm = 16'h1234; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_pre_wren", rf_wren, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_wren", rf_wren, 0);
    chk("abort_resv", res_valid, 0);
    chk("abort_wdat", rf_wdat, 0);
    chk("abort_rw", rf_rw, 0);
    chk("abort_res_data", res_data, 0);
    chk("abort_ready", cmd_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_rel_ready0", cmd_ready, 0);
    @(posedge clk); #1;
    chk("abort_rel_ready1", cmd_ready, 1);
    chk("abort_r7_kept", rf[7], 16'h0000);
    $display("abort during WRITE: r7=%h", rf[7]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
